// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV64M multiply/divide sequencer (shift-add multiplier,
// restoring divider) with valid/ready handshakes on both sides.
// Optional feature macro: MULDIV_FAST_MUL_EN. When defined, MUL/MULW use a
// combinational multiplier at acceptance and complete in one cycle.
module muldiv_seq #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned HW = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic [XLEN-1:0] sext32(input logic [HW-1:0] v);
    return {{(XLEN-HW){v[HW-1]}}, v};
  endfunction

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [XLEN-1:0]  reg_a, reg_a_n;   // multiplicand / dividend-quotient shifter
  logic [XLEN-1:0]  reg_b, reg_b_n;   // multiplier / divisor magnitude
  logic [XLEN-1:0]  acc, acc_n;       // product accumulator / partial remainder
  logic             mul_q, mul_n;
  logic             w_q, w_n;
  logic             rem_q, rem_n;
  logic             negq_q, negq_n;
  logic             negr_q, negr_n;
  logic [XLEN-1:0]  result_n;
  logic             in_ready_n, out_valid_n, busy_n;

  // Incoming op decode
  logic op_mul, op_w, op_sgn, op_rem, op_ill;
  always_comb begin
    op_mul = 1'b0;
    op_w   = 1'b0;
    op_sgn = 1'b0;
    op_rem = 1'b0;
    op_ill = 1'b0;
    case (op)
      4'd0: op_mul = 1'b1;
      4'd1: op_sgn = 1'b1;
      4'd2: ;
      4'd3: begin op_sgn = 1'b1; op_rem = 1'b1; end
      4'd4: op_rem = 1'b1;
      4'd5: begin op_mul = 1'b1; op_w = 1'b1; end
      4'd6: begin op_w = 1'b1; op_sgn = 1'b1; end
      4'd7: op_w = 1'b1;
      4'd8: begin op_w = 1'b1; op_sgn = 1'b1; op_rem = 1'b1; end
      4'd9: begin op_w = 1'b1; op_rem = 1'b1; end
      default: op_ill = 1'b1;
    endcase
  end

  // Operand extension, magnitudes and special-case detection at acceptance
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg, spec_raw, spec_res;
  logic            a_neg, b_neg, div_zero, ovf;
  always_comb begin
    if (op_w) begin
      a_ext = op_sgn ? sext32(srca[HW-1:0]) : XLEN'(srca[HW-1:0]);
      b_ext = op_sgn ? sext32(srcb[HW-1:0]) : XLEN'(srcb[HW-1:0]);
      min_neg = sext32(32'h8000_0000);
    end else begin
      a_ext = srca;
      b_ext = srcb;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg    = op_sgn & a_ext[XLEN-1];
    b_neg    = op_sgn & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    ovf      = op_sgn && (a_ext == min_neg) && (b_ext == '1);
    if (div_zero) spec_raw = op_rem ? a_ext : '1;
    else          spec_raw = op_rem ? '0 : a_ext;
    spec_res = op_w ? sext32(spec_raw[HW-1:0]) : spec_raw;
  end

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle product for the fast multiply path
  logic [XLEN-1:0] prod, fast_res;
  always_comb begin
    prod     = srca * srcb;
    fast_res = op_w ? sext32(prod[HW-1:0]) : prod;
  end
`endif

  // One iteration of the shift-add multiplier and restoring divider, plus final result
  logic [XLEN-1:0] acc_m, a_m, b_m, acc_d, a_d, q_fix, r_fix, fin_raw, fin;
  logic [XLEN:0]   sh, trial;
  logic            ge;
  logic [CNT_W-1:0] last_cnt;
  always_comb begin
    acc_m   = acc + (reg_b[0] ? reg_a : '0);
    a_m     = reg_a << 1;
    b_m     = reg_b >> 1;
    sh      = {acc, reg_a[XLEN-1]};
    trial   = sh - {1'b0, reg_b};
    ge      = ~trial[XLEN];
    acc_d   = ge ? trial[XLEN-1:0] : sh[XLEN-1:0];
    a_d     = {reg_a[XLEN-2:0], ge};
    q_fix   = negq_q ? -a_d : a_d;
    r_fix   = negr_q ? -acc_d : acc_d;
    fin_raw = mul_q ? acc_m : (rem_q ? r_fix : q_fix);
    fin     = w_q ? sext32(fin_raw[HW-1:0]) : fin_raw;
    last_cnt = w_q ? CNT_W'(HW - 1) : CNT_W'(XLEN - 1);
  end

  // Next-state and next-register logic
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    reg_a_n  = reg_a;
    reg_b_n  = reg_b;
    acc_n    = acc;
    mul_n    = mul_q;
    w_n      = w_q;
    rem_n    = rem_q;
    negq_n   = negq_q;
    negr_n   = negr_q;
    result_n = result;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            cnt_n  = '0;
            mul_n  = op_mul;
            w_n    = op_w;
            rem_n  = op_rem;
            negq_n = a_neg ^ b_neg;
            negr_n = a_neg;
            acc_n  = '0;
            if (op_ill) begin
              result_n = '0;
              state_n  = DONE;
            end else if (!op_mul && (div_zero || ovf)) begin
              result_n = spec_res;
              state_n  = DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (op_mul) begin
              result_n = fast_res;
              state_n  = DONE;
`endif
            end else if (op_mul) begin
              reg_a_n = srca;
              reg_b_n = srcb;
              state_n = CALC;
            end else begin
              reg_a_n = op_w ? (a_mag << HW) : a_mag;
              reg_b_n = b_mag;
              state_n = CALC;
            end
          end
        end
        CALC: begin
          cnt_n   = cnt + CNT_W'(1);
          reg_a_n = mul_q ? a_m : a_d;
          reg_b_n = mul_q ? b_m : reg_b;
          acc_n   = mul_q ? acc_m : acc_d;
          if (cnt == last_cnt) begin
            result_n = fin;
            state_n  = DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == DONE);
    busy_n      = (state_n != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      reg_a     <= '0;
      reg_b     <= '0;
      acc       <= '0;
      mul_q     <= 1'b0;
      w_q       <= 1'b0;
      rem_q     <= 1'b0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      result    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      reg_a     <= reg_a_n;
      reg_b     <= reg_b_n;
      acc       <= acc_n;
      mul_q     <= mul_n;
      w_q       <= w_n;
      rem_q     <= rem_n;
      negq_q    <= negq_n;
      negr_q    <= negr_n;
      result    <= result_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      busy      <= busy_n;
    end
  end

endmodule
